// File: rtl/scan_sequencer.sv
// Search-cycle sequencer: sweeps H then V servo, samples the ADC per point, strobes GT on new maxima, parks at best.
// Optional build macro SCAN_ADC_AVG4_EN: average four conversions per point instead of one.
`timescale 1ns/1ps
module scan_sequencer #(
    parameter int unsigned PW_MIN      = 5000,
    parameter int unsigned PW_MAX      = 25000,
    parameter int unsigned PW_STEP     = 500,
    parameter int unsigned SETTLE_CYC  = 2000000,
    parameter int unsigned ADC_TIMEOUT = 1024,
    parameter int unsigned HOLD_CYC    = 100000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        AUTO,
    input  logic [11:0] ADC_DATA,
    input  logic        ADC_VALID,
    input  logic [11:0] LV,
    input  logic [31:0] pulseWidth_max_H,
    input  logic [31:0] pulseWidth_max_V,
    output logic        ADC_START,
    output logic        GT,
    output logic        MAX_CLR,
    output logic [31:0] pulseWidth_H,
    output logic [31:0] pulseWidth_V,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);
    localparam logic [31:0] PW_MIN_L      = 32'(PW_MIN);
    localparam logic [31:0] PW_MAX_L      = 32'(PW_MAX);
    localparam logic [31:0] PW_STEP_L     = 32'(PW_STEP);
    localparam logic [31:0] SETTLE_LAST   = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST  = 32'(ADC_TIMEOUT - 1);
    localparam logic [31:0] HOLD_LAST     = 32'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SETTLE, S_SAMPLE, S_CMP, S_NEXT, S_PARK, S_HOLD
    } state_t;

    state_t      state_q;
    logic        axis_q;
    logic [31:0] cnt_q;
    logic [31:0] pw_h_q, pw_v_q;
    logic        adc_start_q, gt_q, max_clr_q, busy_q, done_q, err_q;
`ifdef SCAN_ADC_AVG4_EN
    logic [1:0]  conv_q;
    logic [13:0] sum_q;
    logic [13:0] sum_d;
`endif

    logic [31:0] pw_act_d, pw_inc_d;
    logic        at_max_d;

    // Step candidate for the active axis; the clamp test runs before the add so it never wraps.
    always_comb begin
        pw_act_d = axis_q ? pw_v_q : pw_h_q;
        at_max_d = (pw_act_d >= PW_MAX_L);
        pw_inc_d = (pw_act_d > (PW_MAX_L - PW_STEP_L)) ? PW_MAX_L : (pw_act_d + PW_STEP_L);
`ifdef SCAN_ADC_AVG4_EN
        sum_d    = sum_q + {2'b00, ADC_DATA};
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            axis_q      <= 1'b0;
            cnt_q       <= '0;
            pw_h_q      <= PW_MIN_L;
            pw_v_q      <= PW_MIN_L;
            adc_start_q <= 1'b0;
            gt_q        <= 1'b0;
            max_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef SCAN_ADC_AVG4_EN
            conv_q      <= '0;
            sum_q       <= '0;
`endif
        end else begin
            adc_start_q <= 1'b0;
            gt_q        <= 1'b0;
            max_clr_q   <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        err_q     <= 1'b0;
                        max_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_CLR;
                    end
                end
                S_CLR: begin
                    axis_q  <= 1'b0;
                    pw_h_q  <= PW_MIN_L;
                    pw_v_q  <= PW_MIN_L;
                    cnt_q   <= '0;
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q       <= '0;
                        adc_start_q <= 1'b1;
`ifdef SCAN_ADC_AVG4_EN
                        conv_q      <= '0;
                        sum_q       <= '0;
`endif
                        state_q     <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_SAMPLE: begin
                    // A strobe on the last timeout cycle still counts as a sample.
                    if (ADC_VALID) begin
                        cnt_q <= '0;
`ifdef SCAN_ADC_AVG4_EN
                        if (conv_q == 2'd3) begin
                            gt_q    <= (sum_d[13:2] > LV);
                            state_q <= S_CMP;
                        end else begin
                            sum_q       <= sum_d;
                            conv_q      <= conv_q + 2'd1;
                            adc_start_q <= 1'b1;
                        end
`else
                        gt_q    <= (ADC_DATA > LV);
                        state_q <= S_CMP;
`endif
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_CMP;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_CMP: begin
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    // Max-hold outputs have absorbed any GT from S_CMP by now.
                    if (!at_max_d) begin
                        if (axis_q) pw_v_q <= pw_inc_d;
                        else        pw_h_q <= pw_inc_d;
                        state_q <= S_SETTLE;
                    end else if (!axis_q) begin
                        axis_q  <= 1'b1;
                        pw_h_q  <= pulseWidth_max_H;
                        pw_v_q  <= PW_MIN_L;
                        state_q <= S_SETTLE;
                    end else begin
                        pw_h_q  <= pulseWidth_max_H;
                        pw_v_q  <= pulseWidth_max_V;
                        state_q <= S_PARK;
                    end
                end
                S_PARK: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= AUTO ? S_HOLD : S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_HOLD: begin
                    if (START) begin
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        max_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_CLR;
                    end else if (!AUTO) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == HOLD_LAST) begin
                        cnt_q     <= '0;
                        max_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_CLR;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ADC_START    = adc_start_q;
    assign GT           = gt_q;
    assign MAX_CLR      = max_clr_q;
    assign pulseWidth_H = pw_h_q;
    assign pulseWidth_V = pw_v_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERR          = err_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: point-level scan model, ADC responder, max-hold register model and a per-cycle compare process.
`timescale 1ns/1ps
module tb_scan_sequencer;
    localparam int PW_MIN = 100, PW_MAX = 200, PW_STEP = 30;
    localparam int SETTLE_CYC = 4, ADC_TIMEOUT = 16, HOLD_CYC = 8;
`ifdef SCAN_ADC_AVG4_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif

    logic        CLK = 1'b0, RST_N = 1'b0, START = 1'b0, AUTO = 1'b0;
    logic [11:0] ADC_DATA = '0, LV = '0;
    logic        ADC_VALID = 1'b0;
    logic [31:0] max_h = '0, max_v = '0;
    logic        ADC_START, GT, MAX_CLR, BUSY, DONE, ERR;
    logic [31:0] pulseWidth_H, pulseWidth_V;

    always #5 CLK = ~CLK;

    scan_sequencer #(
        .PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .PW_STEP(PW_STEP),
        .SETTLE_CYC(SETTLE_CYC), .ADC_TIMEOUT(ADC_TIMEOUT), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .AUTO(AUTO),
        .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID), .LV(LV),
        .pulseWidth_max_H(max_h), .pulseWidth_max_V(max_v),
        .ADC_START(ADC_START), .GT(GT), .MAX_CLR(MAX_CLR),
        .pulseWidth_H(pulseWidth_H), .pulseWidth_V(pulseWidth_V),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    typedef struct { int h; int v; bit gt; int nstart; bit err_before; } pt_t;
    typedef struct { int val; bit first; } conv_t;

    int    n_checks = 0, n_fail = 0;
    pt_t   exp_q[$];
    conv_t adc_q[$];
    int    park_h, park_v;
    bit    park_err;
    int    samp[10][4];
    int    hold_val = 0;
    int    n_starts = 0, n_gts = 0, n_clr = 0;

    task automatic check(input string name, input longint got, input longint expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    // Expected scan from the rules: point list, strict-greater maxima, timeouts abort a point.
    task automatic build_model();
        int pos[$];
        int p, lv, bh, bv, n;
        bit err;
        p = PW_MIN;
        forever begin
            pos.push_back(p);
            if (p >= PW_MAX) break;
            p = (p + PW_STEP > PW_MAX) ? PW_MAX : p + PW_STEP;
        end
        n = pos.size();
        lv = 0; bh = 0; bv = 0; err = 0;
        exp_q.delete(); adc_q.delete();
        for (int i = 0; i < 2 * n; i++) begin
            pt_t e;
            int sum;
            bit to;
            e.h = (i < n) ? pos[i] : bh;
            e.v = (i < n) ? PW_MIN : pos[i - n];
            e.err_before = err;
            e.nstart = 0; sum = 0; to = 0;
            for (int k = 0; k < NCONV && !to; k++) begin
                conv_t c;
                c.val = samp[i][k]; c.first = (k == 0);
                adc_q.push_back(c);
                e.nstart++;
                if (samp[i][k] < 0) to = 1; else sum += samp[i][k];
            end
            e.gt = !to && ((sum / NCONV) > lv);
            if (to) err = 1;
            if (e.gt) begin lv = sum / NCONV; bh = e.h; bv = e.v; end
            exp_q.push_back(e);
        end
        park_h = bh; park_v = bv; park_err = err;
    endtask

    task automatic set_pts(input int d[10]);
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < 4; k++) samp[i][k] = d[i];
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!DONE && k < budget) begin @(negedge CLK); k++; end
        check(name, DONE, 1);
    endtask

    // ADC front end: two-cycle conversion latency, -1 means the strobe is withheld.
    initial begin : responder
        int sum;
        sum = 0;
        forever begin
            @(posedge CLK); #1;
            while (ADC_START && RST_N) begin
                conv_t c;
                if (adc_q.size() == 0) begin c.val = 0; c.first = 1'b1; end
                else c = adc_q.pop_front();
                if (c.first) sum = 0;
                if (c.val < 0) begin
                    @(posedge CLK); #1;
                end else begin
                    sum += c.val;
                    hold_val = (NCONV == 4) ? (sum >> 2) : c.val;
                    repeat (2) begin @(posedge CLK); #1; end
                    ADC_VALID = 1'b1; ADC_DATA = 12'(c.val);
                    @(posedge CLK); #1;
                    ADC_VALID = 1'b0; ADC_DATA = '0;
                end
            end
        end
    end

    // Max-hold register array.
    initial begin : maxhold
        forever begin
            @(negedge CLK);
            if (MAX_CLR) begin
                LV = '0; max_h = '0; max_v = '0;
            end else if (GT) begin
                LV = 12'(hold_val); max_h = pulseWidth_H; max_v = pulseWidth_V;
            end
        end
    end

    // Compare process.
    initial begin : compare
        int starts_left, gt_seen;
        bit pend_valid, pend_gt, in_scan;
        pt_t e;
        starts_left = 0; gt_seen = 0; pend_valid = 0; pend_gt = 0; in_scan = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                in_scan = 0; pend_valid = 0; starts_left = 0;
            end else begin
                if (MAX_CLR) begin n_clr++; in_scan = 1; pend_valid = 0; starts_left = 0; end
                if (GT) begin n_gts++; gt_seen++; end
                if (ADC_START) begin
                    n_starts++;
                    if (starts_left == 0) begin
                        if (pend_valid) check("gt_per_point", gt_seen, pend_gt);
                        check("adc_start_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("point_h", pulseWidth_H, e.h);
                            check("point_v", pulseWidth_V, e.v);
                            check("err_so_far", ERR, e.err_before);
                            pend_gt = e.gt; gt_seen = 0; pend_valid = 1;
                            starts_left = e.nstart - 1;
                        end
                    end else begin
                        starts_left--;
                    end
                end
                if (DONE) begin
                    if (pend_valid) check("gt_per_point", gt_seen, pend_gt);
                    pend_valid = 0;
                    check("park_h", pulseWidth_H, park_h);
                    check("park_v", pulseWidth_V, park_v);
                    check("err_at_done", ERR, park_err);
                    check("points_left", exp_q.size(), 0);
                    in_scan = 0;
                end
                check("busy", BUSY, in_scan);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "bench watchdog expired");
    end

    initial begin : stim
        int d1[10], d2[10], d3[10];
        int k, base_s, base_g, base_c;
        d1 = '{10, 50, 40, 70, 20, 5, 90, 90, 30, 1};
        d2 = '{10, 50, -1, 70, 20, 5, 90, 90, 30, 1};
        d3 = '{30, 20, 10, 5, 1, 40, 10, 50, 50, 0};

        RST_N = 1'b0; tick(3);
        check("rst_h", pulseWidth_H, 100);
        check("rst_v", pulseWidth_V, 100);
        check("rst_adc_start", ADC_START, 0);
        check("rst_gt", GT, 0);
        check("rst_max_clr", MAX_CLR, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        RST_N = 1'b1; tick(2);

        // Reset in the middle of the settle for H point 130.
        set_pts(d1); build_model();
        pulse_start();
        k = 0;
        while (pulseWidth_H != 130 && k < 200) begin tick(1); k++; end
        check("reach_h130", pulseWidth_H, 130);
        RST_N = 1'b0;
        tick(1);
        check("midrst_h", pulseWidth_H, 100);
        check("midrst_v", pulseWidth_V, 100);
        check("midrst_busy", BUSY, 0);
        check("midrst_adc_start", ADC_START, 0);
        check("midrst_max_clr", MAX_CLR, 0);
        RST_N = 1'b1;
        exp_q.delete(); adc_q.delete();
        base_s = n_starts;
        tick(30);
        check("no_start_after_reset", n_starts - base_s, 0);

        // Full sweep with GT on 10, 50, 70 (H) and the first 90 (V).
        set_pts(d1); build_model();
        check("model_v_start_h", exp_q[5].h, 190);
        base_s = n_starts; base_g = n_gts;
        pulse_start();
        tick(15);
        pulse_start();
        wait_done("done_scan1", 1000);
        check("scan1_park_h", pulseWidth_H, 190);
        check("scan1_park_v", pulseWidth_V, 130);
        check("scan1_starts", n_starts - base_s, 10 * NCONV);
        check("scan1_gts", n_gts - base_g, 4);
        check("scan1_err", ERR, 0);
        tick(2);
        check("scan1_done_once", DONE, 0);
        check("scan1_idle", BUSY, 0);

        // Withheld conversion at H point 160.
        set_pts(d2); build_model();
        base_s = n_starts; base_g = n_gts;
        pulse_start();
        k = 0;
        while (!(ADC_START && pulseWidth_H == 160) && k < 500) begin tick(1); k++; end
        check("reach_h160_sample", pulseWidth_H, 160);
        k = 0;
        while (!ERR && k < 40) begin tick(1); k++; end
        check("err_latency", k, ADC_TIMEOUT);
        wait_done("done_scan2", 1000);
        check("scan2_park_h", pulseWidth_H, 190);
        check("scan2_park_v", pulseWidth_V, 130);
        check("scan2_starts", n_starts - base_s, 9 * NCONV + 1);
        check("scan2_gts", n_gts - base_g, 4);
        tick(10);
        check("err_sticky", ERR, 1);

        // Automatic rescan after hold.
        AUTO = 1'b1;
        set_pts(d3); build_model();
        check("model_park_v", park_v, 160);
        pulse_start();
        check("err_cleared_on_start", ERR, 0);
        wait_done("done_scan3", 1000);
        check("scan3_park_h", pulseWidth_H, 100);
        check("scan3_park_v", pulseWidth_V, 160);
        tick(1);
        set_pts(d3); build_model();
        base_c = n_clr;
        k = 1;
        while (!MAX_CLR && k < 30) begin tick(1); k++; end
        check("hold_len", k, HOLD_CYC);
        wait_done("done_scan4", 1000);

        // START during hold restarts at once.
        tick(1);
        set_pts(d3); build_model();
        tick(1);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        check("start_in_hold_clr", MAX_CLR, 1);
        wait_done("done_scan5", 1000);

        // AUTO dropping during hold returns to idle.
        tick(2);
        AUTO = 1'b0;
        base_c = n_clr;
        tick(20);
        check("auto_drop_no_rescan", n_clr - base_c, 0);
        check("auto_drop_idle", BUSY, 0);

`ifdef SCAN_ADC_AVG4_EN
        // Averaging: 8,8,8,11 against LV=8 stays; 8,8,8,12 wins.
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 4; j++) samp[i][j] = 0;
        for (int j = 0; j < 4; j++) begin samp[0][j] = 8; samp[1][j] = 8; samp[2][j] = 8; end
        samp[1][3] = 11; samp[2][3] = 12;
        build_model();
        check("model_avg_8_no_gt", exp_q[1].gt, 0);
        check("model_avg_9_gt", exp_q[2].gt, 1);
        base_g = n_gts;
        pulse_start();
        wait_done("done_avg", 1500);
        check("avg_gts", n_gts - base_g, 2);
        check("avg_park_h", pulseWidth_H, 160);
        check("avg_park_v", pulseWidth_V, 100);
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
